// File: rtl/sw_score_fill.sv
// sw_score_fill: Smith-Waterman forward-fill engine.
// Computes the (N+1)x(N+1) local-alignment score matrix one cell per clock in
// row-major order, streams every cell out of a write port, and reports the
// maximum score together with the linear index of its first occurrence.
// Neighbour values come from a previous-row buffer plus left/diag registers,
// so the score memory is never read back.
// Optional feature macro: SW_FILL_STALL_EN adds a wr_ready back-pressure input.
//
// Write handshake: wr_en is the valid. With SW_FILL_STALL_EN a cell is
// committed only on a cycle where wr_en && wr_ready; while wr_ready is low
// wr_en, wr_addr and wr_data hold steady and the fill pauses. Without the
// macro every cycle with wr_en high is a commit.
module sw_score_fill #(
    parameter int N        = 4,
    parameter int SW       = 32,
    parameter int AW       = 5,
    parameter int MATCH    = 2,
    parameter int MISMATCH = 1,
    parameter int GAP      = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2*N-1:0]  seq1,
    input  logic [2*N-1:0]  seq2,
`ifdef SW_FILL_STALL_EN
    input  logic            wr_ready,
`endif
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic [SW-1:0]   wr_data,
    output logic            busy,
    output logic            done,
    output logic [SW-1:0]   max_score,
    output logic [AW-1:0]   max_index
);

    localparam int CW = (N < 1) ? 1 : $clog2(N + 1);
    localparam logic [CW-1:0] LAST       = CW'(N);
    localparam logic [SW-1:0] MATCH_V    = SW'(MATCH);
    localparam logic [SW-1:0] MISMATCH_V = SW'(MISMATCH);
    localparam logic [SW-1:0] GAP_V      = SW'(GAP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2*N-1:0]  seq1_q, seq2_q;
    logic [CW-1:0]   i_q, j_q;
    logic [AW-1:0]   idx_q;
    logic [SW-1:0]   prev_row [0:N];
    logic [SW-1:0]   left_q, diag_q;

    logic            advance;
    logic [1:0]      base1, base2;
    logic [SW:0]     diag_sum;
    logic [SW-1:0]   top_val, diag_term, top_term, left_term, best_term, cell_score;

    // The output slot may be refilled when it is empty or its cell is being taken.
`ifdef SW_FILL_STALL_EN
    assign advance = !wr_en || wr_ready;
`else
    assign advance = 1'b1;
`endif

    // Pick the two bases compared for the current interior cell.
    always_comb begin
        base1 = 2'b00;
        base2 = 2'b00;
        for (int k = 0; k < N; k++) begin
            if (int'(j_q) == k + 1) base1 = seq1_q[2*k +: 2];
            if (int'(i_q) == k + 1) base2 = seq2_q[2*k +: 2];
        end
    end

    // Cell score: max of the three moves, each clamped to [0, 2^SW-1].
    always_comb begin
        top_val  = prev_row[j_q];
        diag_sum = {1'b0, diag_q} + {1'b0, MATCH_V};
        if (base1 == base2) begin
            diag_term = diag_sum[SW] ? {SW{1'b1}} : diag_sum[SW-1:0];
        end else begin
            diag_term = (diag_q >= MISMATCH_V) ? diag_q - MISMATCH_V : '0;
        end
        top_term  = (top_val >= GAP_V) ? top_val - GAP_V : '0;
        left_term = (left_q >= GAP_V) ? left_q - GAP_V : '0;
        best_term = diag_term;
        if (top_term > best_term)  best_term = top_term;
        if (left_term > best_term) best_term = left_term;
        cell_score = (i_q == '0 || j_q == '0) ? '0 : best_term;
    end

    // Next-state logic for IDLE -> FILL -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = FILL;
            FILL: if (advance && i_q == LAST && j_q == LAST) state_d = DONE;
            DONE: if (advance) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register, fill datapath, registered write port and max tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            seq1_q    <= '0;
            seq2_q    <= '0;
            i_q       <= '0;
            j_q       <= '0;
            idx_q     <= '0;
            left_q    <= '0;
            diag_q    <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            max_score <= '0;
            max_index <= '0;
            for (int k = 0; k <= N; k++) prev_row[k] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    wr_en <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    if (start) begin
                        seq1_q    <= seq1;
                        seq2_q    <= seq2;
                        i_q       <= '0;
                        j_q       <= '0;
                        idx_q     <= '0;
                        max_score <= '0;
                        max_index <= '0;
                    end
                end
                FILL: begin
                    if (advance) begin
                        wr_en       <= 1'b1;
                        busy        <= 1'b1;
                        wr_addr     <= idx_q;
                        wr_data     <= cell_score;
                        prev_row[j_q] <= cell_score;
                        diag_q      <= top_val;
                        left_q      <= cell_score;
                        if (cell_score > max_score) begin
                            max_score <= cell_score;
                            max_index <= idx_q;
                        end
                        idx_q <= idx_q + AW'(1);
                        if (j_q == LAST) begin
                            j_q <= '0;
                            i_q <= i_q + CW'(1);
                        end else begin
                            j_q <= j_q + CW'(1);
                        end
                    end
                end
                DONE: begin
                    if (advance) begin
                        wr_en <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    wr_en <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sw_score_fill.sv
// tb_sw_score_fill: randomized and directed bench for sw_score_fill.
// A matrix-level reference model produces the expected write stream and the
// expected maximum; DUT outputs are sampled on the falling clock edge.
module tb_sw_score_fill;

    localparam int N        = 4;
    localparam int SW       = 32;
    localparam int AW       = 5;
    localparam int MATCH    = 2;
    localparam int MISMATCH = 1;
    localparam int GAP      = 1;
    localparam int SQW      = 2 * N;
    localparam int CELLS    = (N + 1) * (N + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [SQW-1:0]  seq1 = '0;
    logic [SQW-1:0]  seq2 = '0;
    logic            wr_ready = 1'b1;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [SW-1:0]   wr_data;
    logic            busy;
    logic            done;
    logic [SW-1:0]   max_score;
    logic [AW-1:0]   max_index;

    int checks = 0;
    int errors = 0;

    logic [SW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [SW-1:0] exp_max;
    logic [AW-1:0] exp_idx;
    logic [SW-1:0] last_got [CELLS];

    // Clock generation.
    always #5 clk = ~clk;

    sw_score_fill #(
        .N(N), .SW(SW), .AW(AW), .MATCH(MATCH), .MISMATCH(MISMATCH), .GAP(GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .seq1      (seq1),
        .seq2      (seq2),
`ifdef SW_FILL_STALL_EN
        .wr_ready  (wr_ready),
`endif
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .max_score (max_score),
        .max_index (max_index)
    );

    task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: whole score matrix with signed integers, then the row-major stream.
    task automatic build_model(input logic [SQW-1:0] s1, input logic [SQW-1:0] s2);
        int h [N+1][N+1];
        int best;
        exp_q.delete();
        exp_addr_q.delete();
        for (int i = 0; i <= N; i++) begin
            for (int j = 0; j <= N; j++) begin
                if (i == 0 || j == 0) begin
                    h[i][j] = 0;
                end else begin
                    int d, t, l, m;
                    d = h[i-1][j-1] + ((s1[2*(j-1) +: 2] == s2[2*(i-1) +: 2]) ? MATCH : -MISMATCH);
                    t = h[i-1][j] - GAP;
                    l = h[i][j-1] - GAP;
                    m = 0;
                    if (d > m) m = d;
                    if (t > m) m = t;
                    if (l > m) m = l;
                    h[i][j] = m;
                end
            end
        end
        best = 0;
        exp_max = '0;
        exp_idx = '0;
        for (int i = 0; i <= N; i++) begin
            for (int j = 0; j <= N; j++) begin
                exp_q.push_back(SW'(h[i][j]));
                exp_addr_q.push_back(AW'(i * (N + 1) + j));
                if (h[i][j] > best) begin
                    best    = h[i][j];
                    exp_max = SW'(h[i][j]);
                    exp_idx = AW'(i * (N + 1) + j);
                end
            end
        end
    endtask

    // One fill: start pulse (or held start), optional reset abort, optional stall.
    task automatic run_fill(input logic [SQW-1:0] s1, input logic [SQW-1:0] s2, input bit hold,
                            input int abort_addr, input int stall_addr, input int stall_len);
        int n = 0, commits = 0, busy_cyc = 0, first_n = -1, done_n = -1, held = 0, stall_left = 0;
        bit stalled = 0;
        bit ready;
        build_model(s1, s2);
        @(negedge clk);
        seq1  = s1;
        seq2  = s2;
        start = 1'b1;
        @(posedge clk);
        while (n < 200 && done_n < 0) begin
            @(negedge clk);
            if (n == 0 && !hold) start = 1'b0;
            if (abort_addr >= 0 && wr_en && int'(wr_addr) == abort_addr) begin
                rst_n = 1'b0;
                start = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check("abort_wr_en", wr_en, 0);
                check("abort_busy", busy, 0);
                check("abort_wr_addr", wr_addr, 0);
                check("abort_max", max_score, 0);
                rst_n = 1'b1;
                return;
            end
            if (stall_len > 0 && !stalled && wr_en && int'(wr_addr) == stall_addr) begin
                stalled    = 1;
                stall_left = stall_len;
            end
            ready = (stall_left == 0);
            wr_ready = ready;
            if (stall_left > 0) stall_left--;
            if (wr_en && int'(wr_addr) == stall_addr) held++;
            if (busy) busy_cyc++;
            if (wr_en && ready) begin
                if (first_n < 0) first_n = n;
                if (exp_q.size() == 0) begin
                    check("extra_write", 1, 0);
                end else begin
                    check("wr_addr", wr_addr, exp_addr_q.pop_front());
                    check("wr_data", wr_data, exp_q.pop_front());
                end
                if (commits < CELLS) last_got[commits] = wr_data;
                commits++;
            end
            if (done) begin
                done_n = n;
                check("max_score", max_score, exp_max);
                check("max_index", max_index, exp_idx);
                check("done_wr_en", wr_en, 0);
                if (hold) start = 1'b0;
            end
            n++;
        end
        wr_ready = 1'b1;
        check("done_seen", done_n >= 0, 1);
        check("done_latency", done_n, 1 + CELLS + stall_len);
        check("first_write", first_n, 1);
        check("write_count", commits, CELLS);
        check("busy_cycles", busy_cyc, CELLS + stall_len);
        if (stall_len > 0) check("stall_hold", held, stall_len + 1);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("max_hold", max_score, exp_max);
    endtask

    initial begin
        int extra;
        // Reset with random inputs.
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seq1  = SQW'($urandom);
            seq2  = SQW'($urandom);
            start = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_max_score", max_score, 0);
        check("rst_max_index", max_index, 0);
        rst_n = 1'b1;
        start = 1'b0;
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (wr_en || busy || done) extra++;
        end
        check("idle_stays", extra, 0);

        // ACGT vs ACGT: the diagonal accumulates matches.
        run_fill(8'b11100100, 8'b11100100, 0, -1, -1, 0);
        check("acgt_cell6", last_got[6], 2);
        check("acgt_cell7", last_got[7], 1);
        check("acgt_cell12", last_got[12], 4);
        check("acgt_cell18", last_got[18], 6);
        check("acgt_cell24", last_got[24], 8);
        check("acgt_max", max_score, 8);
        check("acgt_idx", max_index, 24);

        // AAAA vs CCCC: nothing scores.
        run_fill(8'h00, 8'h55, 0, -1, -1, 0);
        check("zero_max", max_score, 0);
        check("zero_idx", max_index, 0);

        // Random sequences.
        repeat (8) run_fill(SQW'($urandom), SQW'($urandom), 0, -1, -1, 0);

        // start held high through the whole fill: exactly one fill.
        run_fill(SQW'($urandom), SQW'($urandom), 1, -1, -1, 0);
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (wr_en || busy) extra++;
        end
        check("hold_no_refill", extra, 0);

        // Reset mid-fill, then a clean restart.
        run_fill(8'b11100100, 8'b11100100, 0, 10, -1, 0);
        run_fill(8'b11100100, 8'b11100100, 0, -1, -1, 0);
        check("restart_max", max_score, 8);

`ifdef SW_FILL_STALL_EN
        // Back-pressure on cell 7 for three cycles.
        run_fill(8'b11100100, 8'b11100100, 0, -1, 7, 3);
        check("stall_cell7", last_got[7], 1);
        check("stall_max", max_score, 8);
        check("stall_idx", max_index, 24);
        run_fill(SQW'($urandom), SQW'($urandom), 0, -1, $urandom_range(0, CELLS - 1), 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sw_score_fill.md
# sw_score_fill

Forward-fill engine for the Smith-Waterman local alignment datapath: takes two packed DNA sequences and computes the full (N+1)×(N+1) score matrix, one cell per clock, in row-major order. Each cell is written through a simple write port into the score memory that the traceback stage later reads. The block also reports the maximum cell score and its linear index, which is the traceback start point. The matrix layout is row width N+1, linear index = i·(N+1)+j, so that top = idx−N−1, left = idx−1 and diag = idx−N−2.

## Interface
- N, 4, sequence length in bases; the matrix has (N+1)² cells
- SW, 32, score width (unsigned)
- AW, 5, address width; must satisfy 2^AW ≥ (N+1)²
- MATCH, 2, added on base match
- MISMATCH, 1, subtracted on base mismatch
- GAP, 1, subtracted for a top or left move

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin a fill; sampled only in IDLE
- seq1  in  2N  column sequence; base j = seq1[2j+1:2j] (A=00, C=01, G=10, T=11)
- seq2  in  2N  row sequence; base i = seq2[2i+1:2i]
- wr_en  out  1  score write strobe
- wr_addr  out  AW  linear cell index
- wr_data  out  SW  cell score
- busy  out  1  high while filling
- done  out  1  one-cycle completion pulse
- max_score  out  SW  largest cell score of the last fill
- max_index  out  AW  index of the first cell, in row-major order, holding max_score

## Operation
- FSM states: IDLE → FILL → DONE → IDLE.
- IDLE, start=1: latch seq1/seq2, clear the row/column counters, clear max_score and max_index to 0, and go to FILL. start is ignored in FILL and DONE.
- FILL: one cell per cycle, i outer (0..N), j inner (0..N). wr_en=1, wr_addr=i·(N+1)+j.
  - Row 0 and column 0 write 0.
  - Cells with i,j ≥ 1: score = max(0, diag ± s, top−GAP, left−GAP).
    - s is +MATCH when seq1 base j−1 equals seq2 base i−1; otherwise −MISMATCH.
- Neighbours come from internal storage, with no memory read:
  - A row buffer of N+1 SW-bit entries holds the previous row.
  - A left register holds the last cell written.
  - A diag register holds the pre-overwrite value of prev_row[j−1].
- Arithmetic: additions saturate at 2^SW−1. Subtractions floor at 0, so no wrap-around.
- Max tracking: replace only when the score is strictly greater than max_score. Ties keep the earlier index.
- After cell (N,N), go to DONE: done=1, wr_en=0, busy=0. Next cycle → IDLE.
- max_score and max_index hold until the next accepted start.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, max_score=0, max_index=0; state IDLE; row buffer cleared.
- start sampled high at edge t:
  - Cell k is on the write port during cycle t+1+k, for k = 0..(N+1)²−1.
  - busy is high over the same cycles.
  - done is high in cycle t+1+(N+1)²; max_score and max_index are valid from that cycle.
- Back-to-back fills: the earliest next start is sampled in the cycle after done.
- Reset mid-fill: on the next edge all outputs take reset values and the state goes to IDLE. No partial write is completed after the reset edge.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SW_FILL_STALL_EN defined:
  - Adds input wr_ready (1 bit). A cell is committed only on a cycle with wr_en && wr_ready.
  - While wr_ready=0: wr_addr, wr_data and the internal state hold, and wr_en stays high.
  - done is delayed by the number of stall cycles.
- Undefined: no wr_ready port; every FILL cycle commits.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with random inputs → all outputs 0; state stays IDLE with start=0.
- N=4, seq1=seq2=ACGT (8'b11100100), start at t:
  - Cells 6/12/18/24 = 2/4/6/8; cell 7 = 1.
  - done at t+26; max_score=8, max_index=24.
- seq1=AAAA, seq2=CCCC → all 25 writes are 0; max_score=0, max_index=0; 25 wr_en cycles.
- start held high through FILL and DONE → exactly one fill of 25 writes. A new fill begins only when start is sampled in IDLE.
- rst_n=0 for one cycle while wr_addr=10 → wr_en=0 and busy=0 next cycle. A restart produces the full correct 25-cell sequence from index 0.
- SW_FILL_STALL_EN, ACGT case: wr_ready=0 for 3 cycles while wr_addr=7 → addr 7 and data 1 held for 4 cycles; done at t+29; results unchanged.
